// File: rtl/game_logic.sv
// -----------------------------------------------------------------------------
// game_logic
//
// Purpose:
//   The 2048 game engine. It owns the 4x4 tile grid and the 2-bit game state
//   that the graphics renderer reads. It takes one-hot move commands, slides
//   and merges one line per cycle, spawns a tile after any changing move, and
//   then evaluates win/lose. It runs on the 25 MHz vgaclk domain.
//
// Build option:
//   SPAWN_FOUR_EN - when defined, a spawned tile is code 2 (value 4) whenever
//                   lfsr[7:5] == 3'b000, otherwise code 1. When undefined,
//                   every spawned tile is code 1.
//
// Ports:
//   clk         in   system clock (vgaclk)
//   rst         in   asynchronous active-low reset
//   move[3:0]   in   one-hot move: [0] up, [1] down, [2] left, [3] right
//   move_valid  in   move qualifier, sampled only in IDLE
//   load        in   direct grid load, sampled only in IDLE, beats move_valid
//   load_data   in   cell i is load_data[4*i+3:4*i]
//   grid[0:15]  out  tile codes, cell index = row*4+col, row 0 on top,
//                    code 0 = empty, code n = tile value 2^n
//   state[1:0]  out  0 PLAYING, 1 WON, 2 LOST
//   busy        out  high while init, a move or a load is being processed;
//                    grid/state are only meaningful while busy is low
//
// Handshake: a command (load or move_valid) is taken on a rising clock edge
// only while busy is low; there is no ready/ack, and a command presented while
// busy is high is simply not seen. Completion is signalled by busy falling.
// -----------------------------------------------------------------------------
module game_logic #(
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter logic [3:0]  WIN_TILE = 4'd11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  move,
    input  logic        move_valid,
    input  logic        load,
    input  logic [63:0] load_data,
    output logic [3:0]  grid [0:15],
    output logic [1:0]  state,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_INIT0,
        S_INIT1,
        S_IDLE,
        S_LINE0,
        S_LINE1,
        S_LINE2,
        S_LINE3,
        S_SPAWN,
        S_CHECK
    } fsm_t;

    localparam logic [1:0] GS_PLAYING = 2'd0;
    localparam logic [1:0] GS_WON     = 2'd1;
    localparam logic [1:0] GS_LOST    = 2'd2;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    fsm_t        fsm_q, fsm_d;
    logic [3:0]  grid_q [0:15];
    logic [3:0]  grid_d [0:15];
    logic [1:0]  state_q, state_d;
    logic [1:0]  dir_q, dir_d;
    logic        changed_q, changed_d;
    logic        busy_q, busy_d;
    logic [15:0] lfsr_q, lfsr_d;

    // ------------------------------------------------------------------
    // Grid index of element j of line k. Element 0 sits at the leading
    // edge of the move, so the slide logic only ever compresses toward
    // element 0. For 2-bit j, 3-j is simply ~j.
    // ------------------------------------------------------------------
    function automatic logic [3:0] line_idx(input logic [1:0] dir,
                                            input logic [1:0] k,
                                            input logic [1:0] j);
        logic [1:0] r;
        logic [1:0] c;
        case (dir)
            DIR_UP:   begin r = j;  c = k;  end
            DIR_DOWN: begin r = ~j; c = k;  end
            DIR_LEFT: begin r = k;  c = j;  end
            default:  begin r = k;  c = ~j; end
        endcase
        return {r, c};
    endfunction

    // ------------------------------------------------------------------
    // Slide one line toward element 0 and merge equal neighbours once.
    // The packed array carries a fifth always-zero slot so the lookahead
    // at the last element needs no special case (a nonzero tile never
    // equals 0).
    // ------------------------------------------------------------------
    function automatic logic [15:0] slide_line(input logic [15:0] line_in);
        logic [3:0]  comp [0:4];
        logic [15:0] res;
        logic [2:0]  cnt;
        logic [2:0]  wr;
        logic        skip;
        for (int i = 0; i < 5; i++) begin
            comp[i] = 4'd0;
        end
        res = 16'd0;
        cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (line_in[4*i +: 4] != 4'd0) begin
                comp[cnt[1:0]] = line_in[4*i +: 4];
                cnt            = cnt + 3'd1;
            end
        end
        wr   = 3'd0;
        skip = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (skip) begin
                // Second half of a pair already merged into the previous slot.
                skip = 1'b0;
            end else if (comp[i] != 4'd0) begin
                if (comp[i+1] == comp[i]) begin
                    res[4*wr[1:0] +: 4] = (comp[i] == 4'd15) ? 4'd15 : comp[i] + 4'd1;
                    skip                = 1'b1;
                end else begin
                    res[4*wr[1:0] +: 4] = comp[i];
                end
                wr = wr + 3'd1;
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Spawn target: first empty cell scanning upward (mod 16) from
    // lfsr[3:0]. Shared by INIT0, INIT1 and SPAWN.
    // ------------------------------------------------------------------
    logic [3:0] spawn_cand;
    logic [3:0] spawn_idx;
    logic       spawn_found;
    logic [3:0] spawn_code;

    always_comb begin
        spawn_cand  = 4'd0;
        spawn_idx   = 4'd0;
        spawn_found = 1'b0;
        for (int j = 0; j < 16; j++) begin
            spawn_cand = lfsr_q[3:0] + 4'(j);
            if (!spawn_found && (grid_q[spawn_cand] == 4'd0)) begin
                spawn_found = 1'b1;
                spawn_idx   = spawn_cand;
            end
        end
    end

`ifdef SPAWN_FOUR_EN
    assign spawn_code = (lfsr_q[7:5] == 3'b000) ? 4'd2 : 4'd1;
`else
    assign spawn_code = 4'd1;
`endif

    // ------------------------------------------------------------------
    // End-of-move evaluation flags.
    // ------------------------------------------------------------------
    logic any_win;
    logic any_empty;
    logic any_pair;

    always_comb begin
        any_win   = 1'b0;
        any_empty = 1'b0;
        any_pair  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (grid_q[i] == WIN_TILE) any_win   = 1'b1;
            if (grid_q[i] == 4'd0)     any_empty = 1'b1;
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (grid_q[r*4+c] == grid_q[r*4+c+1]) any_pair = 1'b1;
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (grid_q[r*4+c] == grid_q[(r+1)*4+c]) any_pair = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Current line gathered in leading-edge order, and its slid version.
    // ------------------------------------------------------------------
    logic [1:0]  line_k;
    logic [15:0] line_in;
    logic [15:0] line_out;

    always_comb begin
        case (fsm_q)
            S_LINE1: line_k = 2'd1;
            S_LINE2: line_k = 2'd2;
            S_LINE3: line_k = 2'd3;
            default: line_k = 2'd0;
        endcase
        line_in = 16'd0;
        for (int j = 0; j < 4; j++) begin
            line_in[4*j +: 4] = grid_q[line_idx(dir_q, line_k, 2'(j))];
        end
        line_out = slide_line(line_in);
    end

    logic move_onehot;
    assign move_onehot = (move != 4'd0) && ((move & (move - 4'd1)) == 4'd0);

    // Fibonacci LFSR, taps 16,14,13,11 (bits 0,2,3,5 in right-shift form).
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    // ------------------------------------------------------------------
    // Next-state / datapath.
    // ------------------------------------------------------------------
    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        dir_d     = dir_q;
        changed_d = changed_q;
        for (int i = 0; i < 16; i++) begin
            grid_d[i] = grid_q[i];
        end

        case (fsm_q)
            S_INIT0: begin
                if (spawn_found) grid_d[spawn_idx] = spawn_code;
                fsm_d = S_INIT1;
            end
            S_INIT1: begin
                if (spawn_found) grid_d[spawn_idx] = spawn_code;
                fsm_d = S_IDLE;
            end
            S_IDLE: begin
                if (load) begin
                    for (int i = 0; i < 16; i++) begin
                        grid_d[i] = load_data[4*i +: 4];
                    end
                    fsm_d = S_CHECK;
                end else if (move_valid && (state_q == GS_PLAYING) && move_onehot) begin
                    case (move)
                        4'b0001: dir_d = DIR_UP;
                        4'b0010: dir_d = DIR_DOWN;
                        4'b0100: dir_d = DIR_LEFT;
                        default: dir_d = DIR_RIGHT;
                    endcase
                    changed_d = 1'b0;
                    fsm_d     = S_LINE0;
                end
            end
            S_LINE0, S_LINE1, S_LINE2, S_LINE3: begin
                for (int j = 0; j < 4; j++) begin
                    grid_d[line_idx(dir_q, line_k, 2'(j))] = line_out[4*j +: 4];
                end
                if (line_out != line_in) changed_d = 1'b1;
                case (fsm_q)
                    S_LINE0: fsm_d = S_LINE1;
                    S_LINE1: fsm_d = S_LINE2;
                    S_LINE2: fsm_d = S_LINE3;
                    default: fsm_d = S_SPAWN;
                endcase
            end
            S_SPAWN: begin
                // A changing move always leaves at least one empty cell.
                if (changed_q && spawn_found) grid_d[spawn_idx] = spawn_code;
                fsm_d = S_CHECK;
            end
            S_CHECK: begin
                if (any_win)                      state_d = GS_WON;
                else if (!any_empty && !any_pair) state_d = GS_LOST;
                else                              state_d = GS_PLAYING;
                fsm_d = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase

        busy_d = (fsm_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q     <= S_INIT0;
            state_q   <= GS_PLAYING;
            dir_q     <= DIR_UP;
            changed_q <= 1'b0;
            busy_q    <= 1'b1;
            lfsr_q    <= SEED;
            for (int i = 0; i < 16; i++) begin
                grid_q[i] <= 4'd0;
            end
        end else begin
            fsm_q     <= fsm_d;
            state_q   <= state_d;
            dir_q     <= dir_d;
            changed_q <= changed_d;
            busy_q    <= busy_d;
            lfsr_q    <= lfsr_d;
            for (int i = 0; i < 16; i++) begin
                grid_q[i] <= grid_d[i];
            end
        end
    end

    assign grid  = grid_q;
    assign state = state_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_game_logic.sv
`timescale 1ns/1ps
module tb_game_logic;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam logic [3:0]  WIN_TILE = 4'd11;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  move = 4'd0;
  logic        move_valid = 1'b0;
  logic        load = 1'b0;
  logic [63:0] load_data = 64'd0;
  logic [3:0]  grid [0:15];
  logic [1:0]  state;
  logic        busy;

  always #5 clk = ~clk;

  game_logic #(.SEED(SEED), .WIN_TILE(WIN_TILE)) dut (
    .clk(clk),
    .rst(rst),
    .move(move),
    .move_valid(move_valid),
    .load(load),
    .load_data(load_data),
    .grid(grid),
    .state(state),
    .busy(busy)
  );

  // ---------------- reference model ----------------
  int          tests = 0;
  int          fails = 0;
  logic [65:0] exp_q[$];   // {state, packed grid}
  int          len_q[$];   // expected busy-high cycles
  int          ref_grid [16];
  int          ref_state;
  logic [15:0] ref_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return (l >> 1) | (16'(fb) << 15);
  endfunction

  function automatic logic [15:0] lfsr_ahead(input logic [15:0] l, input int n);
    logic [15:0] v;
    v = l;
    for (int i = 0; i < n; i++) v = lfsr_step(v);
    return v;
  endfunction

  // Free-running copy of the spawn LFSR, held at SEED during reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) ref_lfsr <= SEED;
    else      ref_lfsr <= lfsr_step(ref_lfsr);
  end

  function automatic void ref_spawn(input logic [15:0] l);
    int start;
    int code;
    start = int'(l[3:0]);
`ifdef SPAWN_FOUR_EN
    code = (l[7:5] == 3'b000) ? 2 : 1;
`else
    code = 1;
`endif
    for (int s = 0; s < 16; s++) begin
      if (ref_grid[(start + s) % 16] == 0) begin
        ref_grid[(start + s) % 16] = code;
        return;
      end
    end
  endfunction

  function automatic int ref_eval();
    bit full;
    bit pair;
    full = 1;
    pair = 0;
    for (int i = 0; i < 16; i++) if (ref_grid[i] == int'(WIN_TILE)) return 1;
    for (int i = 0; i < 16; i++) if (ref_grid[i] == 0) full = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (c < 3 && ref_grid[r*4+c] == ref_grid[r*4+c+1]) pair = 1;
        if (r < 3 && ref_grid[r*4+c] == ref_grid[(r+1)*4+c]) pair = 1;
      end
    end
    return (full && !pair) ? 2 : 0;
  endfunction

  // Cell of element j (counted from the leading edge) of line k.
  function automatic int cell_of(input int d, input int k, input int j);
    case (d)
      0: return j * 4 + k;         // up: column k, top first
      1: return (3 - j) * 4 + k;   // down: column k, bottom first
      2: return k * 4 + j;         // left: row k, left first
      default: return k * 4 + 3 - j;
    endcase
  endfunction

  // Applies a 2048 move to ref_grid; returns 1 if anything changed.
  function automatic bit ref_slide(input int d);
    bit changed;
    int q[$];
    int o[$];
    int a;
    changed = 0;
    for (int k = 0; k < 4; k++) begin
      q.delete();
      o.delete();
      for (int j = 0; j < 4; j++)
        if (ref_grid[cell_of(d, k, j)] != 0) q.push_back(ref_grid[cell_of(d, k, j)]);
      while (q.size() > 0) begin
        a = q.pop_front();
        if (q.size() > 0 && q[0] == a) begin
          void'(q.pop_front());
          o.push_back(a == 15 ? 15 : a + 1);
        end else begin
          o.push_back(a);
        end
      end
      while (o.size() < 4) o.push_back(0);
      for (int j = 0; j < 4; j++) begin
        if (ref_grid[cell_of(d, k, j)] != o[j]) changed = 1;
        ref_grid[cell_of(d, k, j)] = o[j];
      end
    end
    return changed;
  endfunction

  function automatic logic [63:0] ref_pack();
    logic [63:0] p;
    for (int i = 0; i < 16; i++) p[4*i +: 4] = 4'(ref_grid[i]);
    return p;
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic busy_prev = 1'b1;
  int   busy_len  = 0;

  always @(negedge clk) begin
    logic [65:0] e;
    logic [63:0] act;
    int          el;
    if (!rst) begin
      busy_prev = 1'b1;
      busy_len  = 0;
    end else begin
      if (busy === 1'b1) begin
        busy_len++;
      end else if (busy_prev === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: busy fell with no pending expectation at %0t", $time);
        end else begin
          e  = exp_q.pop_front();
          el = len_q.pop_front();
          for (int i = 0; i < 16; i++) act[4*i +: 4] = grid[i];
          tests++;
          if (act !== e[63:0]) begin
            fails++;
            $display("FAIL grid: got %h expected %h at %0t", act, e[63:0], $time);
          end
          tests++;
          if (state !== e[65:64]) begin
            fails++;
            $display("FAIL state: got %0d expected %0d at %0t", state, e[65:64], $time);
          end
          tests++;
          if (busy_len != el) begin
            fails++;
            $display("FAIL busy_len: got %0d expected %0d at %0t", busy_len, el, $time);
          end
        end
        busy_len = 0;
      end
      busy_prev = busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      tests++; fails++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles", busy, n);
    end
  endtask

  task automatic push_init();
    for (int i = 0; i < 16; i++) ref_grid[i] = 0;
    ref_spawn(SEED);
    ref_spawn(lfsr_step(SEED));
    ref_state = 0;
    exp_q.push_back({2'd0, ref_pack()});
    len_q.push_back(1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    move_valid = 1'b0;
    load = 1'b0;
    exp_q.delete();
    len_q.delete();
    push_init();
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic do_load(input logic [63:0] d);
    wait_idle();
    for (int i = 0; i < 16; i++) ref_grid[i] = int'(d[4*i +: 4]);
    ref_state = ref_eval();
    exp_q.push_back({2'(ref_state), ref_pack()});
    len_q.push_back(1);
    load = 1'b1;
    load_data = d;
    @(negedge clk);
    load = 1'b0;
    load_data = 64'(($urandom()));
  endtask

  task automatic do_move(input logic [3:0] m);
    int  d;
    bit  ch;
    logic [15:0] l5;
    wait_idle();
    if ($countones(m) == 1 && ref_state == 0) begin
      d  = (m == 4'b0001) ? 0 : (m == 4'b0010) ? 1 : (m == 4'b0100) ? 2 : 3;
      l5 = lfsr_ahead(ref_lfsr, 5);   // LFSR value in the SPAWN cycle
      ch = ref_slide(d);
      if (ch) ref_spawn(l5);
      ref_state = ref_eval();
      exp_q.push_back({2'(ref_state), ref_pack()});
      len_q.push_back(6);
      move = m;
      move_valid = 1'b1;
      @(negedge clk);
      move_valid = 1'b0;
    end else begin
      move = m;
      move_valid = 1'b1;
      @(negedge clk);
      move_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (busy !== 1'b0) begin
          fails++;
          $display("FAIL ignored_move_busy: got %b expected 0 (move %b)", busy, m);
        end
        @(negedge clk);
      end
    end
  endtask

  function automatic logic [63:0] random_grid();
    logic [63:0] g;
    int r;
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 9);
      g[4*i +: 4] = (r < 5) ? 4'd0 : 4'($urandom_range(1, 4));
    end
    if ($urandom_range(0, 7) == 0) begin
      r = $urandom_range(0, 14);
      g[4*r +: 4] = 4'd10;
      g[4*(r+1) +: 4] = 4'd10;
    end
    return g;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] d;
    logic [3:0]  m;

    // 1: reset release and two initial tiles
    do_reset();

    // 2: row 0 = {1,1,2,2}, move left
    d = 64'd0;
    d[3:0] = 4'd1; d[7:4] = 4'd1; d[11:8] = 4'd2; d[15:12] = 4'd2;
    do_load(d);
    do_move(4'b0100);

    // 3: column 0 all ones, move down
    d = 64'd0;
    for (int r = 0; r < 4; r++) d[4*(r*4) +: 4] = 4'd1;
    do_load(d);
    do_move(4'b0010);

    // 4: nothing can move left
    d = 64'd0;
    d[3:0] = 4'd1;
    do_load(d);
    do_move(4'b0100);

    // Saturating merge 15+15
    d = 64'd0;
    d[4*8 +: 4] = 4'd15; d[4*9 +: 4] = 4'd15;
    do_load(d);
    do_move(4'b0100);

    // Non-one-hot moves are ignored
    do_move(4'b0101);
    do_move(4'b0000);

    // 5: reach WIN_TILE, then moves are ignored
    d = 64'd0;
    d[4*5 +: 4] = 4'd10; d[4*6 +: 4] = 4'd10;
    do_load(d);
    do_move(4'b1000);
    do_move(4'b0001);

    // 6: checkerboard -> LOST, then clear back to PLAYING
    d = 64'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        d[4*(r*4+c) +: 4] = ((r + c) % 2 == 1) ? 4'd2 : 4'd1;
    do_load(d);
    do_move(4'b0010);
    do_load(64'd0);

    // Reset in the middle of a move restarts init
    do_load(random_grid());
    if (ref_state == 0) begin
      do_move(4'b0001);
      @(negedge clk);
    end
    do_reset();

    // Randomised mix of loads and moves
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_load(random_grid());
      end else begin
        if ($urandom_range(0, 6) == 0) m = 4'($urandom_range(0, 15));
        else m = 4'(1 << $urandom_range(0, 3));
        do_move(m);
      end
    end

    wait_idle();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
